// File: rtl/bidir_mem_pkg.sv
// Shared sizing constants for the bidirectional-bus scratch memory.
package bidir_mem_pkg;

  localparam int DEF_AWIDTH = 5;
  localparam int DEF_DWIDTH = 8;
  localparam int DEF_DEPTH  = 2 ** DEF_AWIDTH;

endpackage

// File: rtl/bidir_mem_io.sv
// Tristate driver for the shared data bus; also returns the resolved bus value as write data.
module bidir_mem_io
  import bidir_mem_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              drive_en,
  input  logic [DWIDTH-1:0] dout,
  inout  wire  [DWIDTH-1:0] bus,
  output logic [DWIDTH-1:0] din
);

  assign bus = drive_en ? dout : {DWIDTH{1'bz}};
  assign din = bus;

endmodule

// File: rtl/bidir_mem.sv
// Flop-based RAM with synchronous write and zero-latency read over one shared bus.
module bidir_mem
  import bidir_mem_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [AWIDTH-1:0] addr,
  inout  wire  [DWIDTH-1:0] data
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] mem_d [DEPTH];
  logic [DWIDTH-1:0] wdata;
  logic              drive_en;

  // Write has priority over read so the memory never fights the external writer.
  assign drive_en = rd & ~wr & ~rst;

  always_comb begin
    mem_d = mem_q;
    if (wr) begin
      mem_d[addr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  bidir_mem_io #(
    .DWIDTH(DWIDTH)
  ) u_io (
    .drive_en(drive_en),
    .dout    (mem_q[addr]),
    .bus     (data),
    .din     (wdata)
  );

endmodule

// File: tb/tb_bidir_mem.sv
// Randomized and directed checks of bidir_mem against a simple array model of the store.
module tb_bidir_mem;
  import bidir_mem_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  wr = 1'b0;
  logic                  rd = 1'b0;
  logic [DEF_AWIDTH-1:0] addr = '0;
  logic                  tb_oe = 1'b1;
  logic [DEF_DWIDTH-1:0] tb_dout = '0;
  wire  [DEF_DWIDTH-1:0] data;

  int checks = 0;
  int failures = 0;

  logic [DEF_DWIDTH-1:0] model [DEF_DEPTH];

  assign data = tb_oe ? tb_dout : {DEF_DWIDTH{1'bz}};

  always #5 clk = ~clk;

  bidir_mem dut (
    .clk (clk),
    .rst (rst),
    .wr  (wr),
    .rd  (rd),
    .addr(addr),
    .data(data)
  );

  // Reference store: cleared by reset, otherwise takes the bus value on a write.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEF_DEPTH; i++) model[i] = '0;
    end else if (wr) begin
      model[addr] = tb_dout;
    end
  end

  // Bus must show the stored word when reading, otherwise exactly what the bench drives.
  always @(negedge clk) begin
    logic [DEF_DWIDTH-1:0] exp;
    if (!rst && rd && !wr) exp = model[addr];
    else exp = tb_dout;
    checks++;
    if (data !== exp) begin
      failures++;
      $display("FAIL bus_cycle t=%0t rst=%0b wr=%0b rd=%0b addr=%0d got=%h want=%h",
               $time, rst, wr, rd, addr, data, exp);
    end
  end

  task automatic step(input logic r, input logic w, input logic rdv,
                      input logic [DEF_AWIDTH-1:0] a, input logic [DEF_DWIDTH-1:0] v);
    @(posedge clk);
    #1;
    rst = r;
    wr = w;
    rd = rdv;
    addr = a;
    tb_oe = !(rdv && !w && !r);
    tb_dout = v;
    #1;
    $display("txn t=%0t rst=%0b wr=%0b rd=%0b addr=%0d bus=%h", $time, r, w, rdv, a, data);
  endtask

  task automatic check_lit(input string name, input logic [DEF_DWIDTH-1:0] exp);
    checks++;
    if (data !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, data, exp);
    end
  endtask

  initial begin
    // Reset then basic write at the address extremes
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'hFF);
    step(0, 1, 0, 31, 8'h00);
    step(0, 0, 1, 0, 8'h00);
    check_lit("read_addr0_ff", 8'hFF);
    step(0, 0, 1, 31, 8'h00);
    check_lit("read_addr31_00", 8'h00);

    // Descending-address sweep then read back
    for (int i = 0; i <= 30; i++) step(0, 1, 0, 5'(31 - i), 8'(i));
    for (int a = 31; a >= 1; a--) begin
      step(0, 0, 1, 5'(a), 8'h00);
      check_lit($sformatf("sweep_addr%0d", a), 8'(31 - a));
    end

    // Bus release: addr 1 holds 8'h1E, bench drives a disjoint pattern
    step(0, 0, 0, 1, 8'hE1);
    check_lit("release_idle", 8'hE1);
    step(0, 1, 0, 2, 8'h5A);
    check_lit("release_write", 8'h5A);

    // Reset clears, and the bus is not driven while rst is high
    step(0, 1, 0, 5, 8'hA5);
    step(1, 0, 1, 5, 8'h00);
    check_lit("rst_rd_no_drive", 8'h00);
    step(0, 0, 1, 5, 8'h00);
    check_lit("after_rst_addr5", 8'h00);

    // wr and rd together: write wins; first store a complementary word at 7
    step(0, 1, 0, 7, 8'hC3);
    step(0, 1, 1, 7, 8'h3C);
    check_lit("wr_rd_bus", 8'h3C);
    step(0, 0, 1, 7, 8'h00);
    check_lit("wr_rd_readback", 8'h3C);

    // Overwrite
    step(0, 1, 0, 0, 8'h11);
    step(0, 1, 0, 0, 8'h22);
    step(0, 0, 1, 0, 8'h00);
    check_lit("overwrite_addr0", 8'h22);

    // Randomized traffic checked every cycle by the model comparison
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, DEF_DEPTH - 1)), 8'($urandom));
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
